// File: rtl/booth_result_collector.sv
// ----------------------------------------------------------------------------
// booth_result_collector
//
// Downstream stage of the sequential Booth multiplier. Detects each completed
// multiplication from the multiplier's level-held `done`, captures the product
// and its add/sub op counts into a small FIFO, presents the FIFO head over a
// valid/ready handshake, and keeps a running signed accumulation of every
// accepted product together with drop statistics.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, 2..16)
//   ACC_W  accumulator width in bits (>= 33)
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous active-high reset
//   product        multiplier result (signed two's complement)
//   total_add_ops  multiplier add-op count
//   total_sub_ops  multiplier sub-op count
//   done           multiplier completion (level, may stay high)
//   clear_acc      synchronous accumulator clear pulse
//   out_valid      FIFO head valid
//   out_ready      consumer accepts head
//   out_product    head product (0 while empty)
//   out_add_ops    head add count (0 while empty)
//   out_sub_ops    head sub count (0 while empty)
//   acc            running sum of accepted products
//   count          FIFO occupancy
//   overflow       sticky: a result was dropped
//   drop_count     dropped results, saturating at 255
//   state_dbg      capture FSM state (0=SYNC, 1=ARMED, 2=HELD)
//
// Configuration macro:
//   BOOTH_COLLECT_ACC_SAT_EN  when defined, acc saturates at the signed
//                             ACC_W-bit limits instead of wrapping.
//
// Handshake: a head entry transfers on every clk edge where out_valid and
// out_ready are both 1. out_valid depends only on occupancy (never on
// out_ready), and out_ready may be asserted regardless of out_valid.
// ----------------------------------------------------------------------------
module booth_result_collector #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              product,
    input  logic [4:0]               total_add_ops,
    input  logic [4:0]               total_sub_ops,
    input  logic                     done,
    input  logic                     clear_acc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_product,
    output logic [4:0]               out_add_ops,
    output logic [4:0]               out_sub_ops,
    output logic [ACC_W-1:0]         acc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [1:0]               state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // ------------------------------------------------------------------
    // Capture FSM: one push attempt per rising edge of `done`. SYNC waits
    // for done to be seen low so a done held across reset release is not
    // mistaken for a new completion.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   push_attempt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        push_attempt = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (!done) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (done) begin
                    push_attempt = 1'b1;
                    state_d      = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!done) state_d = ST_ARMED;
            end
            default: state_d = ST_SYNC;
        endcase
    end

    assign state_dbg = state_q;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [31:0]   mem_product [DEPTH];
    logic [4:0]    mem_add     [DEPTH];
    logic [4:0]    mem_sub     [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic full;
    logic pop;
    logic push_ok;
    logic push_drop;

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push_attempt && (!full || pop);
    assign push_drop = push_attempt && !push_ok;

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_product[wr_ptr_q] <= product;
            mem_add[wr_ptr_q]     <= total_add_ops;
            mem_sub[wr_ptr_q]     <= total_sub_ops;
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count       = count_q;
    assign out_product = out_valid ? mem_product[rd_ptr_q] : 32'd0;
    assign out_add_ops = out_valid ? mem_add[rd_ptr_q]     : 5'd0;
    assign out_sub_ops = out_valid ? mem_sub[rd_ptr_q]     : 5'd0;

    // ------------------------------------------------------------------
    // Accumulator. clear_acc zeroes the base before any same-cycle add.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_push_val;

    assign acc_base = clear_acc ? '0 : acc_q;
    assign prod_ext = {{(ACC_W-32){product[31]}}, product};
    assign acc_sum  = acc_base + prod_ext;

`ifdef BOOTH_COLLECT_ACC_SAT_EN
    // Signed overflow: both operands share a sign that the sum lost.
    logic acc_ovf;
    assign acc_ovf = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1]  != acc_base[ACC_W-1]);
    always_comb begin
        acc_push_val = acc_sum;
        if (acc_ovf) begin
            if (acc_base[ACC_W-1]) acc_push_val = {1'b1, {(ACC_W-1){1'b0}}};
            else                   acc_push_val = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign acc_push_val = acc_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (push_ok) begin
            acc_q <= acc_push_val;
        end else if (clear_acc) begin
            acc_q <= '0;
        end
    end

    assign acc = acc_q;

    // ------------------------------------------------------------------
    // Drop statistics, cleared only by reset.
    // ------------------------------------------------------------------
    logic       overflow_q;
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else if (push_drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: doc/booth_result_collector.md
Name: booth_result_collector

Overview:
- Downstream stage of the sequential Booth multiplier.
- Detects each completed multiplication from the multiplier's level-held `done`, captures `product` and the add/sub op counts, and buffers them in a small FIFO. Results are presented to the consumer over a valid/ready handshake.
- Keeps a running signed accumulation of all accepted products, plus overflow/drop statistics.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- ACC_W, 40: accumulator width in bits; must be ≥ 33.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- product  in  32  multiplier result, treated as signed two's complement.
- total_add_ops  in  5  multiplier add-op count.
- total_sub_ops  in  5  multiplier sub-op count.
- done  in  1  multiplier completion; level, may stay high many cycles.
- clear_acc  in  1  synchronous accumulator clear pulse.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_product  out  32  head product.
- out_add_ops  out  5  head add count.
- out_sub_ops  out  5  head sub count.
- acc  out  ACC_W  running sum of accepted products.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; a result was dropped.
- drop_count  out  8  number of dropped results; saturates at 255.

Behaviour:
- Reset, when rst=1 at a clk edge:
  - FSM goes to SYNC; FIFO is emptied.
  - count=0, out_valid=0, acc=0, overflow=0, drop_count=0.
  - out_product, out_add_ops and out_sub_ops read 0 while empty.
  - Reset mid-operation discards all buffered entries; a done that is held high is not captured.
- Capture FSM, registered:
  - SYNC: done=0 → ARMED; otherwise stay.
  - ARMED: done=1 → push attempt with this cycle's product/op inputs, then → HELD.
  - HELD: done=0 → ARMED.
  - Result: exactly one push attempt per done 0→1 transition. A done already high at reset release is ignored.
- Push attempt:
  - Accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
  - Otherwise dropped: overflow←1, drop_count increments (saturating), acc unchanged.
- Pop: occurs when out_valid && out_ready at a clk edge; the head advances.
- Simultaneous accepted push and pop: count unchanged.
- Read/write pointers wrap modulo DEPTH.
- out_valid = (count≠0).
- Head outputs come from registered storage, combinationally selected by the read pointer.
- Latency:
  - done sampled high in ARMED at edge N → entry written at edge N.
  - If the FIFO was empty, out_valid=1 and the head holds that entry in the cycle after edge N.
- Accumulator:
  - On an accepted push: acc ← acc + sign_extend(product, ACC_W), modulo 2^ACC_W.
  - clear_acc=1 without a push: acc ← 0.
  - clear_acc=1 with an accepted push: acc ← sign_extend(product). The clear applies first.
  - A dropped push never changes acc.
- Statistics:
  - overflow and drop_count are cleared only by rst.
  - Ready does not depend on valid; out_valid does not depend on out_ready.

Optional Feature:
- Macro: BOOTH_COLLECT_ACC_SAT_EN.
- Defined: acc saturates instead of wrapping.
  - Positive overflow clamps to 2^(ACC_W-1)-1.
  - Negative overflow clamps to -2^(ACC_W-1).
  - Clear and sign-extension rules are unchanged.
- Undefined: modulo-2^ACC_W wrap as above.

Test Plan:
- Release rst with done held high, then hold done for 10 cycles → no push (count=0, acc=0). Drop done for 1 cycle, raise with product=0x00000064 → count=1, out_product=0x64, acc=100.
- Hold done high for 20 cycles after one rise with out_ready=0 → exactly one entry (count=1), not 20.
- With out_ready=0, push 5 results (DEPTH=4) with products 1,2,3,4,5 → count=4, overflow=1, drop_count=1, acc=10. Then drain with out_ready=1 → heads read 1,2,3,4 in order, then out_valid=0.
- With FIFO full and out_ready=1, raise done in the same cycle as a pop, with product=0xFFFFFFFF → push accepted, count stays 4, acc decreases by 1, overflow unchanged.
- Push product=0x7FFFFFFF 300 times, then assert clear_acc together with a push of product=0xFFFFFFFE → acc=-2 sign-extended (0xFFFFFFFFFE for ACC_W=40).
- Build with BOOTH_COLLECT_ACC_SAT_EN and ACC_W=33, push 0x7FFFFFFF three times → acc=0x0FFFFFFFF (2^32-1, saturated). Without the macro → acc wraps to 0x17FFFFFFD.
